wavelet_transform: RTL and testbench
====================================

// Module: wavelet_transform
// PURPOSE
//  Streaming multi-level Haar wavelet filter bank in the Caravel user area.
//  - Samples 8-bit signed values on rising edges of an external data strobe (i_data_clk).
//  - Decomposes them into per-level detail channels plus one final approximation channel.
//  - Drives the channel chosen by i_select_output_channel onto an 8-bit output bus.
//  - All pins reach mprj_io through user_project_wrapper; rst is driven from la_data_in[0].
// PARAMETERS
//  WIDTH       8  sample / coefficient width (two's complement)
//  NUM_LEVELS  4  number of cascaded Haar levels (1..8)
// PORTS
//  clk                        in   1      system clock; every flop is on its rising edge
//  rst                        in   1      synchronous active-high reset
//  i_data_clk                 in   1      async sample strobe from mprj_io[8]; its rising edge marks a new sample
//  i_value                    in   WIDTH  signed input sample, mprj_io[16:9]
//  i_select_output_channel    in   8      output channel select, mprj_io[24:17]
//  o_multiplexed_wavelet_out  out  WIDTH  selected coefficient, mprj_io[32:25]
//  o_active                   out  1      1-cycle pulse when the selected channel's coefficient is updated, mprj_io[33]
// BEHAVIOUR
//  Reset:
//  - All registers clear to 0: synchronizers, phases, previous samples, detail/approx registers, outputs.
//  - o_active is 0 during reset.
//  - Reset mid-operation discards any half-formed pair at every level.
//  Input capture:
//  - i_data_clk passes through a 2-flop synchronizer, then a rising-edge detector, giving strobe S.
//  - i_value is registered in parallel through 2 flops, so it is aligned with S.
//  - Source must hold i_value stable from >=3 clk before to >=3 clk after the i_data_clk rise.
//  - Successive rises must be >=NUM_LEVELS+3 clk apart; closer rises are not required to be handled.
//  Level L (1..NUM_LEVELS): holds prev sample p_L, phase bit ph_L, detail register D_L.
//  - An event carries sample x.
//  - If ph_L==0: p_L<=x, ph_L<=1; no output.
//  - If ph_L==1: ph_L<=0.
//    - D_L <= (x - p_L) >>> 1
//    - approximation (p_L + x) >>> 1 is emitted as the event into level L+1 one cycle later.
//  - Level 1's events are the S strobes, carrying the synchronized i_value.
//  - Final approximation register A is written with level NUM_LEVELS's approximation.
//  - Arithmetic: sign-extend to WIDTH+1, add/subtract, arithmetic shift right by 1 (floor), keep the low WIDTH bits.
//    No overflow is possible.
//  Timing (strobe S high in cycle E):
//  - Level-1 registers update at the end of E.
//  - Level L updates at the end of E+L-1.
//  - A updates in the same cycle as D_NUM_LEVELS.
//  Output mux (registered, 1-cycle latency, re-evaluated every cycle):
//  - sel < NUM_LEVELS:  D_(sel+1)
//  - sel == NUM_LEVELS: A
//  - sel > NUM_LEVELS:  0
//  o_active:
//  - High for exactly one cycle: the first cycle in which o_multiplexed_wavelet_out shows a freshly written value
//    of the currently selected register.
//  - Changing sel alone never pulses o_active.
//  - A write of an equal value still pulses.
//  Simultaneous events: different levels updating in the same cycle are independent.
// TESTING
//  1. Reset: rst=1 for 4 clk -> out=0x00, o_active=0; rises on i_data_clk while rst=1 are ignored.
//  2. Samples 10, 20 with sel=0 -> out=5 (0x05), one o_active pulse at the second sample, none at the first.
//  3. Samples 10, 20, 40, 60:
//     - sel=0 -> 10 after the 4th sample
//     - sel=1 -> 17 (from approx 15, 50)
//     - level-2 approximation (15+50)>>>1 = 32 is passed into level 3
//  4. Samples -128 (0x80), 127 (0x7F) with sel=0 -> D1=127 (0x7F); level-1 approx=-1 (0xFF) passed into level 2.
//  5. 16 samples of constant 100, sel=4 -> A=100, all D_L=0; sel=9 -> out=0 and no o_active pulses.
//  6. Assert rst after the 1st of a pair, then send 30, 50 -> D1=10.
//     Confirms the stale half-pair was discarded; output latency matches the timing rules above.

Source files
------------

// File: rtl/wavelet_transform_if.sv
// Pin-level bundle of the wavelet filter bank: sample strobe/value, channel select,
// and the multiplexed coefficient output with its update pulse.
interface wavelet_transform_if #(
    parameter int WIDTH = 8
);
    logic             i_data_clk;
    logic [WIDTH-1:0] i_value;
    logic [7:0]       i_select_output_channel;
    logic [WIDTH-1:0] o_multiplexed_wavelet_out;
    logic             o_active;

    modport master (
        output i_data_clk, i_value, i_select_output_channel,
        input  o_multiplexed_wavelet_out, o_active
    );

    modport slave (
        input  i_data_clk, i_value, i_select_output_channel,
        output o_multiplexed_wavelet_out, o_active
    );
endinterface

// File: rtl/wavelet_transform.sv
// Streaming multi-level Haar filter bank: per-level detail registers plus a final
// approximation, one channel selected onto a registered output with an update pulse.
module wavelet_transform #(
    parameter int WIDTH      = 8,
    parameter int NUM_LEVELS = 4
) (
    input logic             clk,
    input logic             rst,
    wavelet_transform_if.slave bus
);
    localparam int IDXW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    logic             dclk_meta, dclk_sync, dclk_prev;
    logic             strobe;
    logic [WIDTH-1:0] val_meta, val_sync;

    logic [WIDTH-1:0] p_q   [NUM_LEVELS];
    logic [WIDTH-1:0] d_q   [NUM_LEVELS];
    logic [WIDTH-1:0] apx_q [NUM_LEVELS];
    logic             done_q[NUM_LEVELS];

    logic [WIDTH-1:0] mux_val, out_q;
    logic             mux_wr, active_q;

    // Value path has the same two-flop depth as the strobe path so they line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            dclk_meta <= 1'b0;
            dclk_sync <= 1'b0;
            dclk_prev <= 1'b0;
            val_meta  <= '0;
            val_sync  <= '0;
        end else begin
            dclk_meta <= bus.i_data_clk;
            dclk_sync <= dclk_meta;
            dclk_prev <= dclk_sync;
            val_meta  <= bus.i_value;
            val_sync  <= val_meta;
        end
    end

    assign strobe = dclk_sync & ~dclk_prev;

    for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_level
        logic             ev;
        logic [WIDTH-1:0] x;
        logic             ph;
        logic [WIDTH:0]   sum, dif;

        if (l == 0) begin : g_first
            assign ev = strobe;
            assign x  = val_sync;
        end else begin : g_next
            assign ev = done_q[l-1];
            assign x  = apx_q[l-1];
        end

        assign sum = {x[WIDTH-1], x} + {p_q[l][WIDTH-1], p_q[l]};
        assign dif = {x[WIDTH-1], x} - {p_q[l][WIDTH-1], p_q[l]};

        // done_q doubles as the "fresh value" flag for d_q/apx_q and as the
        // event into the next level; the last level's apx_q is the final A.
        always_ff @(posedge clk) begin
            if (rst) begin
                p_q[l]    <= '0;
                d_q[l]    <= '0;
                apx_q[l]  <= '0;
                done_q[l] <= 1'b0;
                ph        <= 1'b0;
            end else begin
                done_q[l] <= ev & ph;
                if (ev) begin
                    if (!ph) begin
                        p_q[l] <= x;
                        ph     <= 1'b1;
                    end else begin
                        ph       <= 1'b0;
                        d_q[l]   <= dif[WIDTH:1];
                        apx_q[l] <= sum[WIDTH:1];
                    end
                end
            end
        end
    end

    always_comb begin
        mux_val = '0;
        mux_wr  = 1'b0;
        if (bus.i_select_output_channel < 8'(NUM_LEVELS)) begin
            mux_val = d_q[bus.i_select_output_channel[IDXW-1:0]];
            mux_wr  = done_q[bus.i_select_output_channel[IDXW-1:0]];
        end else if (bus.i_select_output_channel == 8'(NUM_LEVELS)) begin
            mux_val = apx_q[NUM_LEVELS-1];
            mux_wr  = done_q[NUM_LEVELS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            active_q <= 1'b0;
        end else begin
            out_q    <= mux_val;
            active_q <= mux_wr;
        end
    end

    assign bus.o_multiplexed_wavelet_out = out_q;
    assign bus.o_active                  = active_q;
endmodule

// File: tb/tb_wavelet_transform.sv
// Directed bench for wavelet_transform: hand-computed Haar coefficients, output
// latency and o_active pulse counts.
module tb_wavelet_transform;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   act_cnt = 0;
    int   c0;

    wavelet_transform_if #(.WIDTH(8)) bus ();

    wavelet_transform #(.WIDTH(8), .NUM_LEVELS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.o_active) act_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] v);
        bus.i_value = v;
        repeat (4) @(negedge clk);
        bus.i_data_clk = 1'b1;
        repeat (4) @(negedge clk);
        bus.i_data_clk = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic set_sel(input logic [7:0] s);
        bus.i_select_output_channel = s;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.i_data_clk              = 1'b0;
        bus.i_value                 = '0;
        bus.i_select_output_channel = '0;

        // Reset, with a strobe pulse that must be ignored
        rst = 1'b1;
        bus.i_value = 8'd77;
        @(negedge clk);
        bus.i_data_clk = 1'b1;
        @(negedge clk);
        check("rst_out", 32'(bus.o_multiplexed_wavelet_out), 32'h0);
        check("rst_active", 32'(bus.o_active), 32'h0);
        @(negedge clk);
        bus.i_data_clk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_out", 32'(bus.o_multiplexed_wavelet_out), 32'h0);
        check("post_rst_pulses", 32'(act_cnt), 32'd0);

        // 10, 20 -> D1 = 5, one pulse on the second sample only
        do_reset();
        set_sel(8'd0);
        c0 = act_cnt;
        send(8'd10);
        check("pair1_first_pulses", 32'(act_cnt - c0), 32'd0);
        send(8'd20);
        check("pair1_d1", 32'(bus.o_multiplexed_wavelet_out), 32'h05);
        check("pair1_pulses", 32'(act_cnt - c0), 32'd1);

        // 10, 20, 40, 60 -> D1 = 10, D2 = (50-15)>>>1 = 17, D3 still 0
        do_reset();
        set_sel(8'd0);
        send(8'd10);
        send(8'd20);
        send(8'd40);
        send(8'd60);
        check("seq4_d1", 32'(bus.o_multiplexed_wavelet_out), 32'h0A);
        c0 = act_cnt;
        set_sel(8'd1);
        check("seq4_d2", 32'(bus.o_multiplexed_wavelet_out), 32'h11);
        check("sel_change_no_pulse", 32'(act_cnt - c0), 32'd0);
        set_sel(8'd2);
        check("seq4_d3", 32'(bus.o_multiplexed_wavelet_out), 32'h00);

        // Extremes: -128, 127 -> D1 = 127, approx -1 into level 2;
        // then 1, 1 -> approx 1, so D2 = (1 - (-1))>>>1 = 1
        do_reset();
        set_sel(8'd0);
        send(8'h80);
        send(8'h7F);
        check("ext_d1", 32'(bus.o_multiplexed_wavelet_out), 32'h7F);
        send(8'd1);
        send(8'd1);
        set_sel(8'd1);
        check("ext_d2", 32'(bus.o_multiplexed_wavelet_out), 32'h01);

        // Constant 100 over 16 samples -> A = 100, all details 0
        do_reset();
        set_sel(8'd4);
        c0 = act_cnt;
        for (int i = 0; i < 16; i++) send(8'd100);
        check("const_a", 32'(bus.o_multiplexed_wavelet_out), 32'h64);
        check("const_a_pulses", 32'(act_cnt - c0), 32'd1);
        for (int s = 0; s < 4; s++) begin
            set_sel(8'(s));
            check($sformatf("const_d%0d", s + 1), 32'(bus.o_multiplexed_wavelet_out), 32'h0);
        end
        set_sel(8'd9);
        c0 = act_cnt;
        send(8'd100);
        send(8'd100);
        check("sel9_out", 32'(bus.o_multiplexed_wavelet_out), 32'h0);
        check("sel9_pulses", 32'(act_cnt - c0), 32'd0);

        // Reset mid-pair, then 30, 50 -> D1 = 10 with exact latency
        do_reset();
        set_sel(8'd0);
        send(8'd70);
        do_reset();
        send(8'd30);
        bus.i_value = 8'd50;
        repeat (4) @(negedge clk);
        bus.i_data_clk = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_before_out", 32'(bus.o_multiplexed_wavelet_out), 32'h0);
        check("lat_before_active", 32'(bus.o_active), 32'h0);
        @(negedge clk);
        check("lat_d1", 32'(bus.o_multiplexed_wavelet_out), 32'h0A);
        check("lat_active", 32'(bus.o_active), 32'h1);
        @(negedge clk);
        check("lat_active_end", 32'(bus.o_active), 32'h0);
        bus.i_data_clk = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
